avalon_to_wb_bridge: RTL and testbench

Avalon-MM slave to Wishbone master bridge: the reverse direction of the team's Wishbone-to-Avalon bridge. It lets Avalon-side masters (Qsys/Platform Designer DMA, JTAG masters) reach Wishbone peripherals. Each Avalon read or write, optionally a fixed-length burst, becomes one Wishbone cycle. Read data returns through the Avalon pipelined read path (readdatavalid).

---
 rtl/avalon_to_wb_pkg.sv | 26 ++
 rtl/avalon_to_wb_bridge.sv | 181 ++++++++++++++++++
 tb/tb_avalon_to_wb_bridge.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_to_wb_pkg.sv
// Shared types for the Avalon-MM slave to Wishbone master bridge:
// FSM state enum, Wishbone CTI/BTE codes, Avalon response codes.
package avalon_to_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RETRY
  } state_e;

  localparam logic [2:0] CTI_CLASSIC   = 3'b000;
  localparam logic [2:0] CTI_INC_BURST = 3'b010;
  localparam logic [2:0] CTI_END_BURST = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;

  localparam logic [1:0] RESP_OKAY       = 2'b00;
  localparam logic [1:0] RESP_SLAVEERROR = 2'b10;

  // Avalon burstcount of 0 means a single beat.
  function automatic logic [7:0] beat_count(input logic [7:0] bc);
    return (bc == 8'd0) ? 8'd1 : bc;
  endfunction

endpackage

// File: rtl/avalon_to_wb_bridge.sv
// Avalon-MM slave (s_av_*) to Wishbone master (wb_*) bridge, one clock wb_clk_i,
// async active-low wb_rst_ni; bursts honoured when AVALON_TO_WB_BURST_EN is defined.
module avalon_to_wb_bridge
  import avalon_to_wb_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic [AW-1:0]   s_av_address_i,
  input  logic [DW/8-1:0] s_av_byteenable_i,
  input  logic            s_av_read_i,
  input  logic            s_av_write_i,
  input  logic [DW-1:0]   s_av_writedata_i,
  input  logic [7:0]      s_av_burstcount_i,
  output logic            s_av_waitrequest_o,
  output logic [DW-1:0]   s_av_readdata_o,
  output logic            s_av_readdatavalid_o,
  output logic [1:0]      s_av_response_o,
  output logic            bus_err_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic [2:0]      wb_cti_o,
  output logic [1:0]      wb_bte_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_rty_i
);

  localparam logic [AW-1:0] STEP = AW'(DW / 8);

  state_e          state_q, state_d;
  state_e          ret_q;
  logic [7:0]      beats_q;
  logic            burst_q;
  logic [AW-1:0]   adr_q;
  logic [DW/8-1:0] sel_q;
  logic [DW-1:0]   rdata_q;
  logic [1:0]      resp_q;
  logic            rdv_q;
  logic            berr_q;
  logic [7:0]      nbeats;

  logic active;
  logic term;
  logic last;

  assign active = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign term   = wb_ack_i | wb_err_i;
  assign last   = (beats_q == 8'd1);

`ifdef AVALON_TO_WB_BURST_EN
  assign nbeats = beat_count(s_av_burstcount_i);

  always_comb begin
    wb_cti_o = CTI_CLASSIC;
    if (active && burst_q)
      wb_cti_o = last ? CTI_END_BURST : CTI_INC_BURST;
  end
`else
  logic unused_burst;

  assign nbeats       = 8'd1;
  assign wb_cti_o     = CTI_CLASSIC;
  assign unused_burst = ^{s_av_burstcount_i, burst_q};
`endif

  assign wb_bte_o = BTE_LINEAR;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (s_av_read_i)       state_d = ST_READ;
        else if (s_av_write_i) state_d = ST_WRITE;
      end
      ST_READ, ST_WRITE: begin
        if (term) begin
          if (last) state_d = ST_IDLE;
        end else if (wb_rty_i) begin
          state_d = ST_RETRY;
        end
      end
      ST_RETRY: state_d = ret_q;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_av_waitrequest_o = 1'b1;
    unique case (state_q)
      ST_IDLE:  s_av_waitrequest_o = s_av_write_i | ~wb_rst_ni;
      ST_WRITE: s_av_waitrequest_o = ~term;
      default:  s_av_waitrequest_o = 1'b1;
    endcase
  end

  // Write data and enables are live from the Avalon side so each
  // Avalon beat maps directly onto one Wishbone beat.
  always_comb begin
    wb_cyc_o = (state_q != ST_IDLE);
    wb_stb_o = active;
    wb_we_o  = (state_q == ST_WRITE) ||
               ((state_q == ST_RETRY) && (ret_q == ST_WRITE));
    wb_dat_o = '0;
    wb_sel_o = '0;
    unique case (state_q)
      ST_READ: wb_sel_o = sel_q;
      ST_WRITE: begin
        wb_dat_o = s_av_writedata_i;
        wb_sel_o = s_av_byteenable_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ret_q   <= ST_IDLE;
      beats_q <= 8'd0;
      burst_q <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
      rdv_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      rdv_q  <= 1'b0;
      berr_q <= active & wb_err_i;
      unique case (state_q)
        ST_IDLE: begin
          if (s_av_read_i || s_av_write_i) begin
            adr_q   <= s_av_address_i;
            beats_q <= nbeats;
            burst_q <= (nbeats != 8'd1);
          end
          if (s_av_read_i) sel_q <= s_av_byteenable_i;
        end
        ST_READ: begin
          if (term) begin
            rdv_q   <= 1'b1;
            rdata_q <= wb_ack_i ? wb_dat_i : '0;
            resp_q  <= wb_ack_i ? RESP_OKAY : RESP_SLAVEERROR;
            beats_q <= beats_q - 8'd1;
            adr_q   <= adr_q + STEP;
          end else if (wb_rty_i) begin
            ret_q <= ST_READ;
          end
        end
        ST_WRITE: begin
          if (term) begin
            beats_q <= beats_q - 8'd1;
            adr_q   <= adr_q + STEP;
          end else if (wb_rty_i) begin
            ret_q <= ST_WRITE;
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_adr_o             = adr_q;
  assign s_av_readdata_o      = rdata_q;
  assign s_av_response_o      = resp_q;
  assign s_av_readdatavalid_o = rdv_q;
  assign bus_err_o            = berr_q;

endmodule

// File: tb/tb_avalon_to_wb_bridge.sv
// Self-checking bench for avalon_to_wb_bridge: directed scenarios plus
// randomized single-beat traffic against a word-memory reference model.
`timescale 1ns/1ps
module tb_avalon_to_wb_bridge;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] address;
  logic [3:0]    be;
  logic          read, write;
  logic [DW-1:0] wdata;
  logic [7:0]    bc;
  logic          waitreq;
  logic [DW-1:0] rdata;
  logic          rdv;
  logic [1:0]    resp;
  logic          berr;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_o;
  logic [3:0]    wb_sel;
  logic          wb_we, wb_cyc, wb_stb;
  logic [2:0]    wb_cti;
  logic [1:0]    wb_bte;
  logic [DW-1:0] wb_dat_i;
  logic          ack, err, rty;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ref_mem [16];
  logic [31:0] slv_mem [16];

  always #5 clk = ~clk;

  avalon_to_wb_bridge #(.DW(DW), .AW(AW)) dut (
    .wb_clk_i            (clk),
    .wb_rst_ni           (rst_n),
    .s_av_address_i      (address),
    .s_av_byteenable_i   (be),
    .s_av_read_i         (read),
    .s_av_write_i        (write),
    .s_av_writedata_i    (wdata),
    .s_av_burstcount_i   (bc),
    .s_av_waitrequest_o  (waitreq),
    .s_av_readdata_o     (rdata),
    .s_av_readdatavalid_o(rdv),
    .s_av_response_o     (resp),
    .bus_err_o           (berr),
    .wb_adr_o            (wb_adr),
    .wb_dat_o            (wb_dat_o),
    .wb_sel_o            (wb_sel),
    .wb_we_o             (wb_we),
    .wb_cyc_o            (wb_cyc),
    .wb_stb_o            (wb_stb),
    .wb_cti_o            (wb_cti),
    .wb_bte_o            (wb_bte),
    .wb_dat_i            (wb_dat_i),
    .wb_ack_i            (ack),
    .wb_err_i            (err),
    .wb_rty_i            (rty)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    read = 0; write = 0; ack = 0; err = 0; rty = 0;
    address = '0; be = '0; wdata = '0; bc = 8'd1; wb_dat_i = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    #3;
    n_checks++;
    if ({wb_cyc, wb_stb, wb_we, rdv, berr, waitreq} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000001",
               {wb_cyc, wb_stb, wb_we, rdv, berr, waitreq});
    end
    n_checks++;
    if ({wb_adr, wb_dat_o, rdata, resp, wb_cti, wb_bte} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: adr %h dat %h rd %h resp %b cti %b bte %b want 0",
               wb_adr, wb_dat_o, rdata, resp, wb_cti, wb_bte);
    end
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_single_read();
    read = 1; address = 32'h100; be = 4'hF; bc = 8'd1;
    #1;
    n_checks++;
    if (waitreq !== 1'b0) begin
      n_fail++; $display("FAIL rd_accept_wait: got %b want 0", waitreq);
    end
    step();
    read = 0; ack = 1; wb_dat_i = 32'hDEADBEEF;
    #1;
    n_checks++;
    if ({wb_cyc, wb_stb, wb_we, wb_cti, wb_sel} !== {3'b110, 3'b000, 4'hF}) begin
      n_fail++;
      $display("FAIL rd_wb_ctrl: got %b want 1100001111",
               {wb_cyc, wb_stb, wb_we, wb_cti, wb_sel});
    end
    n_checks++;
    if (wb_adr !== 32'h100) begin
      n_fail++; $display("FAIL rd_adr: got %h want 00000100", wb_adr);
    end
    step();
    ack = 0; wb_dat_i = '0;
    #1;
    n_checks++;
    if ({rdv, rdata, resp, wb_cyc} !== {1'b1, 32'hDEADBEEF, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL rd_result: rdv %b data %h resp %b cyc %b want 1 deadbeef 00 0",
               rdv, rdata, resp, wb_cyc);
    end
    step();
    n_checks++;
    if (rdv !== 1'b0) begin
      n_fail++; $display("FAIL rd_rdv_pulse: got %b want 0", rdv);
    end
  endtask

  task automatic test_single_write();
    write = 1; address = 32'h200; wdata = 32'h12345678; be = 4'h3; bc = 8'd1;
    #1;
    n_checks++;
    if (waitreq !== 1'b1) begin
      n_fail++; $display("FAIL wr_present_wait: got %b want 1", waitreq);
    end
    step();
    #1;
    n_checks++;
    if ({wb_cyc, wb_stb, wb_we, wb_sel, wb_dat_o, wb_adr} !==
        {3'b111, 4'h3, 32'h12345678, 32'h200}) begin
      n_fail++;
      $display("FAIL wr_wb_sig: cyc/stb/we %b sel %h dat %h adr %h",
               {wb_cyc, wb_stb, wb_we}, wb_sel, wb_dat_o, wb_adr);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (waitreq !== 1'b1) begin
        n_fail++; $display("FAIL wr_wait_%0d: got %b want 1", i, waitreq);
      end
      if (i < 2) step();
    end
    step();
    ack = 1;
    #1;
    n_checks++;
    if (waitreq !== 1'b0) begin
      n_fail++; $display("FAIL wr_ack_wait: got %b want 0", waitreq);
    end
    step();
    ack = 0; write = 0;
    #1;
    n_checks++;
    if ({wb_cyc, wb_stb, rdv, berr} !== 4'b0000) begin
      n_fail++; $display("FAIL wr_done: got %b want 0000", {wb_cyc, wb_stb, rdv, berr});
    end
    step();
  endtask

  task automatic test_error();
    read = 1; address = 32'h180; be = 4'hF; bc = 8'd1;
    step();
    read = 0; err = 1; wb_dat_i = 32'hFFFFFFFF;
    step();
    err = 0; wb_dat_i = '0;
    #1;
    n_checks++;
    if ({rdv, rdata, resp, berr} !== {1'b1, 32'h0, 2'b10, 1'b1}) begin
      n_fail++;
      $display("FAIL rd_err: rdv %b data %h resp %b berr %b want 1 0 10 1",
               rdv, rdata, resp, berr);
    end
    step();
    n_checks++;
    if ({berr, rdv} !== 2'b00) begin
      n_fail++; $display("FAIL rd_err_pulse: got %b want 00", {berr, rdv});
    end
    write = 1; address = 32'h184; wdata = 32'hA5A5A5A5; be = 4'hF;
    step();
    err = 1;
    #1;
    n_checks++;
    if (waitreq !== 1'b0) begin
      n_fail++; $display("FAIL wr_err_accept: got %b want 0", waitreq);
    end
    step();
    write = 0; err = 0;
    #1;
    n_checks++;
    if ({berr, rdv, wb_cyc} !== 3'b100) begin
      n_fail++; $display("FAIL wr_err: got %b want 100", {berr, rdv, wb_cyc});
    end
    step();
  endtask

  task automatic test_retry();
    read = 1; address = 32'h300; be = 4'hF; bc = 8'd1;
    step();
    read = 0; rty = 1;
    #1;
    n_checks++;
    if ({wb_cyc, wb_stb, wb_adr} !== {2'b11, 32'h300}) begin
      n_fail++; $display("FAIL rty_issue: cyc/stb %b adr %h", {wb_cyc, wb_stb}, wb_adr);
    end
    step();
    rty = 0;
    #1;
    n_checks++;
    if ({wb_cyc, wb_stb, rdv, wb_adr} !== {3'b100, 32'h300}) begin
      n_fail++;
      $display("FAIL rty_gap: cyc/stb/rdv %b adr %h want 100 300",
               {wb_cyc, wb_stb, rdv}, wb_adr);
    end
    step();
    ack = 1; wb_dat_i = 32'hCAFEF00D;
    #1;
    n_checks++;
    if ({wb_cyc, wb_stb, wb_adr} !== {2'b11, 32'h300}) begin
      n_fail++; $display("FAIL rty_reissue: cyc/stb %b adr %h", {wb_cyc, wb_stb}, wb_adr);
    end
    step();
    ack = 0;
    #1;
    n_checks++;
    if ({rdv, rdata, resp} !== {1'b1, 32'hCAFEF00D, 2'b00}) begin
      n_fail++; $display("FAIL rty_done: rdv %b data %h resp %b", rdv, rdata, resp);
    end
    step();
  endtask

  task automatic test_burst();
    read = 1; address = 32'h40; be = 4'hF; bc = 8'd4;
    step();
    read = 0;
`ifdef AVALON_TO_WB_BURST_EN
    for (int k = 0; k < 4; k++) begin
      ack = 1; wb_dat_i = 32'hB0000000 + k;
      #1;
      n_checks++;
      if ({wb_stb, wb_adr, wb_cti, wb_bte} !==
          {1'b1, 32'h40 + 32'(4 * k), (k == 3) ? 3'b111 : 3'b010, 2'b00}) begin
        n_fail++;
        $display("FAIL burst_beat_%0d: stb %b adr %h cti %b bte %b", k, wb_stb, wb_adr, wb_cti, wb_bte);
      end
      if (k > 0) begin
        n_checks++;
        if ({rdv, rdata} !== {1'b1, 32'hB0000000 + 32'(k - 1)}) begin
          n_fail++; $display("FAIL burst_rdv_%0d: rdv %b data %h", k, rdv, rdata);
        end
      end
      step();
    end
    ack = 0;
    #1;
    n_checks++;
    if ({rdv, rdata, wb_cyc} !== {1'b1, 32'hB0000003, 1'b0}) begin
      n_fail++; $display("FAIL burst_last: rdv %b data %h cyc %b", rdv, rdata, wb_cyc);
    end
`else
    ack = 1; wb_dat_i = 32'hB0000000;
    #1;
    n_checks++;
    if ({wb_stb, wb_cti, wb_bte} !== 6'b100000) begin
      n_fail++; $display("FAIL nob_cti: stb %b cti %b bte %b", wb_stb, wb_cti, wb_bte);
    end
    step();
    ack = 0;
    #1;
    n_checks++;
    if ({rdv, rdata, wb_cyc} !== {1'b1, 32'hB0000000, 1'b0}) begin
      n_fail++; $display("FAIL nob_single: rdv %b data %h cyc %b", rdv, rdata, wb_cyc);
    end
`endif
    step();
  endtask

  task automatic test_reset_mid();
    read = 1; address = 32'h80; be = 4'hF; bc = 8'd4;
    step();
    read = 0; ack = 1; wb_dat_i = 32'h11111111;
    step();
    ack = 0;
    #1;
    rst_n = 0;
    #1;
    n_checks++;
    if ({wb_cyc, wb_stb, rdv, waitreq} !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_mid: cyc/stb/rdv/wait %b want 0001", {wb_cyc, wb_stb, rdv, waitreq});
    end
    step();
    rst_n = 1;
    step();
    read = 1; address = 32'h84; bc = 8'd1;
    step();
    read = 0; ack = 1; wb_dat_i = 32'h22222222;
    #1;
    n_checks++;
    if ({wb_cyc, wb_stb, wb_adr} !== {2'b11, 32'h84}) begin
      n_fail++; $display("FAIL rst_fresh_adr: cyc/stb %b adr %h", {wb_cyc, wb_stb}, wb_adr);
    end
    step();
    ack = 0;
    #1;
    n_checks++;
    if ({rdv, rdata, resp} !== {1'b1, 32'h22222222, 2'b00}) begin
      n_fail++; $display("FAIL rst_fresh: rdv %b data %h resp %b", rdv, rdata, resp);
    end
    step();
  endtask

  task automatic test_random();
    bit          is_rd;
    int          idx, w, r, term;
    logic [31:0] a, d, exp;
    logic [3:0]  sel;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = '0;
      slv_mem[i] = '0;
    end
    for (int t = 0; t < 60; t++) begin
      is_rd = 1'($urandom % 2);
      idx   = int'($urandom % 16);
      a     = 32'h1000 + 32'(idx * 4);
      sel   = 4'($urandom_range(1, 15));
      d     = $urandom;
      w     = int'($urandom % 3);
      r     = int'($urandom % 10);
      term  = (r < 7) ? 0 : (r < 8) ? 1 : 2;
      address = a; be = sel; wdata = d;
`ifdef AVALON_TO_WB_BURST_EN
      bc = 8'($urandom % 2);
`else
      bc = 8'($urandom);
`endif
      read = is_rd; write = !is_rd;
      step();
      read = 0;
      #1;
      n_checks++;
      if ({wb_cyc, wb_stb, wb_we, wb_adr, wb_sel} !== {2'b11, !is_rd, a, sel}) begin
        n_fail++;
        $display("FAIL rnd_issue_%0d: cyc/stb/we %b adr %h sel %h want we %b adr %h sel %h",
                 t, {wb_cyc, wb_stb, wb_we}, wb_adr, wb_sel, !is_rd, a, sel);
      end
      repeat (w) step();
      if (term == 2) begin
        rty = 1;
        step();
        rty = 0;
        #1;
        n_checks++;
        if ({wb_cyc, wb_stb, wb_adr} !== {2'b10, a}) begin
          n_fail++;
          $display("FAIL rnd_retry_%0d: cyc/stb %b adr %h want 10 %h", t, {wb_cyc, wb_stb}, wb_adr, a);
        end
        step();
      end
      if (term == 1) begin
        err = 1;
      end else begin
        ack = 1;
        wb_dat_i = slv_mem[idx];
      end
      #1;
      if (!is_rd) begin
        if (term != 1)
          for (int b = 0; b < 4; b++)
            if (wb_sel[b]) slv_mem[idx][8*b +: 8] = wb_dat_o[8*b +: 8];
        n_checks++;
        if (waitreq !== 1'b0) begin
          n_fail++; $display("FAIL rnd_wr_accept_%0d: got %b want 0", t, waitreq);
        end
      end
      step();
      ack = 0; err = 0; write = 0; wb_dat_i = '0;
      #1;
      exp = (term == 1) ? 32'h0 : ref_mem[idx];
      n_checks++;
      if (is_rd && ({rdv, rdata, resp} !== {1'b1, exp, (term == 1) ? 2'b10 : 2'b00})) begin
        n_fail++;
        $display("FAIL rnd_read_%0d: rdv %b data %h resp %b want data %h err %0d",
                 t, rdv, rdata, resp, exp, term == 1);
      end else if (!is_rd && rdv !== 1'b0) begin
        n_fail++; $display("FAIL rnd_wr_rdv_%0d: got %b want 0", t, rdv);
      end
      n_checks++;
      if ({berr, wb_cyc} !== {term == 1, 1'b0}) begin
        n_fail++; $display("FAIL rnd_end_%0d: berr/cyc %b want %b0", t, {berr, wb_cyc}, term == 1);
      end
      if (!is_rd && term != 1)
        for (int b = 0; b < 4; b++)
          if (sel[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
      step();
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (slv_mem[i] !== ref_mem[i]) begin
        n_fail++; $display("FAIL rnd_mem_%0d: got %h want %h", i, slv_mem[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_error();
    test_retry();
    test_burst();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
